// File: rtl/ibus_uart_tx.sv
// rtl/ibus_uart_tx.sv - captures ibus read data after a fixed latency, buffers it and sends each word as two 8N1 UART frames
module ibus_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_LAT       = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren,
  input  logic [15:0] ibus_rdata,
  input  logic        clr_ovf,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // read-strobe delay line
  logic [RD_LAT-1:0] ren_sr_q, ren_sr_d;
  logic              push;

  // FIFO storage and pointers (one extra wrap bit each)
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          empty, full, pop, push_ok, drop;
  logic [15:0]   fifo_rdata;
  logic          ovf_q, ovf_d;

  // transmitter
  state_t        state_q, state_d;
  logic          byte_sel_q, byte_sel_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    nxt_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic          tx_q, tx_d;
  logic          cnt_last;
  logic [7:0]    cur_byte;

  assign push       = ren_sr_q[RD_LAT-1];
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok    = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign cur_byte   = byte_sel_q ? hold_q[15:8] : hold_q[7:0];
  assign nxt_idx    = bit_idx_q + 3'd1;

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) | ~empty;
  assign fifo_full = full;
  assign ovf       = ovf_q;

  // shift ren down the latency pipe; the last stage marks a valid rdata cycle
  always_comb begin
    ren_sr_d    = ren_sr_q;
    ren_sr_d[0] = ren;
    for (int i = 1; i < RD_LAT; i++) begin
      ren_sr_d[i] = ren_sr_q[i-1];
    end
  end

  // FIFO pointer advance and sticky overflow; a new drop wins over clr_ovf
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO data write; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= ibus_rdata;
  end

  // frame sequencer: start, 8 data bits LSB first, stop; low byte then high byte
  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          hold_d     = fifo_rdata;
          byte_sel_d = 1'b0;
          cnt_d      = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = nxt_idx;
            tx_d      = cur_byte[nxt_idx];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else if (!empty) begin
            pop        = 1'b1;
            hold_d     = fifo_rdata;
            byte_sel_d = 1'b0;
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers; reset drops any frame in flight and returns tx high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      cnt_q      <= '0;
      hold_q     <= 16'h0000;
      tx_q       <= 1'b1;
    end else begin
      ren_sr_q   <= ren_sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_ibus_uart_tx.sv
// tb/tb_ibus_uart_tx.sv - self-checking bench for ibus_uart_tx
module tb_ibus_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        ren_a, clr_ovf_a, tx_a, busy_a, full_a, ovf_a;
  logic [15:0] rdata_a;
  logic        ren_b, clr_ovf_b, tx_b, busy_b, full_b, ovf_b;
  logic [15:0] rdata_b;

  int          total;
  int          bad;
  int          cyc;
  logic [7:0]  sb [$];
  int          fstart [$];

  bit          mon_on;
  int          mon_cnt;
  int          mon_k;
  logic [7:0]  mon_byte;
  logic [7:0]  mon_exp;

  ibus_uart_tx #(.CLKS_PER_BIT(4), .RD_LAT(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ren(ren_a), .ibus_rdata(rdata_a), .clr_ovf(clr_ovf_a),
    .tx(tx_a), .busy(busy_a), .fifo_full(full_a), .ovf(ovf_a)
  );

  ibus_uart_tx #(.CLKS_PER_BIT(4), .RD_LAT(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ren(ren_b), .ibus_rdata(rdata_b), .clr_ovf(clr_ovf_b),
    .tx(tx_b), .busy(busy_b), .fifo_full(full_b), .ovf(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n back-to-back reads on dut_a; the first keep words are expected on the line
  task automatic burst(input int n, input logic [15:0] base, input int keep);
    logic [15:0] w;
    for (int k = 0; k <= n; k++) begin
      ren_a = (k < n);
      if (k == 0) begin
        rdata_a = 16'hDEAD;
      end else begin
        w = base + 16'((k - 1) * 257);
        rdata_a = w;
        if (k <= keep) begin
          sb.push_back(w[7:0]);
          sb.push_back(w[15:8]);
        end
      end
      tick(1);
    end
    ren_a   = 1'b0;
    rdata_a = 16'h0000;
  endtask

  task automatic wait_idle_a(input string tag, input int bound);
    for (int i = 0; i < bound && busy_a; i++) tick(1);
    chk(tag, busy_a, 1'b0);
  endtask

  // UART receiver on dut_a: samples mid-bit, checks framing, pops the scoreboard
  initial begin
    mon_on = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_on = 1'b0;
      end else if (!mon_on) begin
        if (tx_a === 1'b0) begin
          mon_on  = 1'b1;
          mon_cnt = 0;
          fstart.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % 4 == 2) begin
          mon_k = mon_cnt / 4;
          if (mon_k == 0) begin
            chk("start_bit", tx_a, 1'b0);
          end else if (mon_k <= 8) begin
            mon_byte[mon_k-1] = tx_a;
          end else begin
            chk("stop_bit", tx_a, 1'b1);
            chk("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
              mon_exp = sb.pop_front();
              chk("frame_byte", mon_byte, mon_exp);
            end
          end
        end
        if (mon_cnt == 39) mon_on = 1'b0;
      end
    end
  end

  initial begin
    int          t_fall;
    logic [19:0] rx_line;
    logic [19:0] exp_line;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ren_a = 1'b0; rdata_a = 16'h0000; clr_ovf_a = 1'b0;
    ren_b = 1'b0; rdata_b = 16'h0000; clr_ovf_b = 1'b0;
    tick(2);
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_full", full_a, 1'b0);
    chk("rst_ovf", ovf_a, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // single word: latency, bytes, total length
    fstart.delete();
    ren_a = 1'b1;
    tick(1);
    ren_a   = 1'b0;
    rdata_a = 16'hA55A;
    sb.push_back(8'h5A);
    sb.push_back(8'hA5);
    tick(1);
    chk("t1_tx_before_fall", tx_a, 1'b1);
    rdata_a = 16'h0000;
    tick(1);
    chk("t1_tx_fall", tx_a, 1'b0);
    t_fall = cyc;
    wait_idle_a("t1_idle", 200);
    chk("t1_word_len", cyc - t_fall, 80);
    chk("t1_tx_idle", tx_a, 1'b1);
    chk("t1_sb_drained", sb.size(), 0);

    // four consecutive reads: contiguous frames
    fstart.delete();
    burst(4, 16'h0001, 4);
    wait_idle_a("t2_idle", 500);
    chk("t2_frames", fstart.size(), 8);
    for (int i = 1; i < fstart.size(); i++) chk("t2_gap", fstart[i] - fstart[i-1], 40);
    if (fstart.size() > 0) chk("t2_busy_len", cyc - fstart[0], 320);
    chk("t2_ovf", ovf_a, 1'b0);
    chk("t2_sb_drained", sb.size(), 0);

    // six consecutive reads: one in holding, four in FIFO, one dropped
    fstart.delete();
    burst(6, 16'h1020, 5);
    chk("t3_full", full_a, 1'b1);
    chk("t3_ovf", ovf_a, 1'b1);

    // clear coinciding with another drop keeps ovf; clear alone drops it
    ren_a = 1'b1;
    tick(1);
    ren_a     = 1'b0;
    rdata_a   = 16'hBEEF;
    clr_ovf_a = 1'b1;
    tick(1);
    chk("t4_clr_with_drop", ovf_a, 1'b1);
    tick(1);
    chk("t4_clr_alone", ovf_a, 1'b0);
    clr_ovf_a = 1'b0;
    rdata_a   = 16'h0000;
    wait_idle_a("t3_idle", 800);
    chk("t3_frames", fstart.size(), 10);
    chk("t3_sb_drained", sb.size(), 0);
    chk("t3_full_after", full_a, 1'b0);

    // reset while in the data bits of the first frame
    fstart.delete();
    burst(2, 16'h7E81, 0);
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx_a, 1'b1);
    chk("t5_rst_busy", busy_a, 1'b0);
    chk("t5_rst_full", full_a, 1'b0);
    tick(2);
    fstart.delete();
    rst_n = 1'b1;
    tick(200);
    chk("t5_no_residual", fstart.size(), 0);
    chk("t5_tx_idle", tx_a, 1'b1);
    chk("t5_busy_idle", busy_a, 1'b0);

    // RD_LAT=3 instance: garbage before the valid cycle must be ignored
    ren_b = 1'b1;
    tick(1);
    ren_b   = 1'b0;
    rdata_b = 16'hFFFF;
    tick(1);
    rdata_b = 16'h0000;
    tick(1);
    rdata_b = 16'h3C96;
    tick(1);
    rdata_b = 16'hAAAA;
    chk("t6_tx_before_fall", tx_b, 1'b1);
    tick(1);
    chk("t6_tx_fall", tx_b, 1'b0);
    exp_line = {1'b1, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0};
    tick(1);
    for (int p = 0; p < 20; p++) begin
      if (p > 0) tick(4);
      rx_line[p] = tx_b;
    end
    chk("t6_line", rx_line, exp_line);
    for (int i = 0; i < 20 && busy_b; i++) tick(1);
    chk("t6_idle", busy_b, 1'b0);
    chk("t6_ovf", ovf_b, 1'b0);
    chk("t6_full", full_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
